// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches to
// instruction memory and drives the IF/ID pipeline register toward decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        id_nop
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_nop_q, id_nop_d;

    logic        deliver;
    logic [31:0] deliver_insn;
    logic        resp_owed;

    // A redirect must not reuse the bus while an accepted fetch is still unanswered.
    assign resp_owed = ((state_q == S_WAIT) && !imem_rvalid) ||
                       ((state_q == S_REQ)  &&  imem_ready)  ||
                       ((state_q == S_DROP) && !imem_rvalid);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_nop_d     = id_nop_q;
        deliver      = 1'b0;
        deliver_insn = imem_rdata;

        if (redirect) begin
            pc_d        = redirect_pc & ~32'h3;
            buf_valid_d = 1'b0;
            id_instr_d  = NOP_INSN;
            id_nop_d    = 1'b1;
            state_d     = resp_owed ? S_DROP : S_REQ;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall) begin
                            deliver = 1'b1;
                            state_d = S_REQ;
                        end else begin
                            buf_d       = imem_rdata;
                            buf_valid_d = 1'b1;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall && buf_valid_q) begin
                        deliver      = 1'b1;
                        deliver_insn = buf_q;
                        buf_valid_d  = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase

            if (deliver) begin
                id_instr_d = deliver_insn;
                id_pc_d    = pc_q;
                id_nop_d   = 1'b0;
                pc_d       = pc_q + 32'd4;
            end else if (!stall) begin
                id_instr_d = NOP_INSN;
                id_nop_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            id_instr_q  <= NOP_INSN;
            id_pc_q     <= '0;
            id_nop_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_nop_q    <= id_nop_d;
        end
    end

    assign imem_req       = (state_q == S_REQ) && !rst;
    assign imem_addr      = pc_q;
    assign id_instruction = id_instr_q;
    assign id_pc          = id_pc_q;
    assign id_nop         = id_nop_q;

endmodule
